// File: rtl/axi_write_pkg.sv
// Shared AXI3 write-side types: burst/response codes, FSM states, captured AW payload.
// Pure declarations; no latency or backpressure of its own.
package axi_write_pkg;

  localparam int ID_W  = 4;
  localparam int LEN_W = 4;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [31:0]      addr;
    logic [LEN_W-1:0] len;
    logic [2:0]       size;
    logic [1:0]       burst;
  } aw_t;

  function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
    return len inside {4'd1, 4'd3, 4'd7, 4'd15};
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat byte address for FIXED/INCR/WRAP bursts.
// Zero latency, no flow control; reserved burst type holds the address.
module axi_burst_addr_gen
  import axi_write_pkg::*;
(
  input  logic [31:0]      addr_i,
  input  logic [2:0]       size_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [1:0]       burst_i,
  output logic [31:0]      next_addr_o
);

  logic [31:0] size_bytes;
  logic [31:0] wrap_mask;

  assign size_bytes = 32'd1 << size_i;
  // Wrap window is (len+1)*size bytes; only power-of-two lengths reach here legally.
  assign wrap_mask  = (({28'd0, len_i} + 32'd1) * size_bytes) - 32'd1;

  always_comb begin
    next_addr_o = addr_i;
    case (burst_i)
      BURST_INCR: next_addr_o = (addr_i & ~(size_bytes - 32'd1)) + size_bytes;
      BURST_WRAP: next_addr_o = (addr_i & ~wrap_mask) | ((addr_i + size_bytes) & wrap_mask);
      default:    next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi_write_slave.sv
// AXI3 write slave: one AW at a time, per-beat memory write pulse, one B per burst.
// mem_we one cycle after each accepted beat; B held until BREADY, AW/W stalled meanwhile.
module axi_write_slave
  import axi_write_pkg::*;
#(
  parameter int          buswidth  = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_SPAN = 4096
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ID_W-1:0]       AWID,
  input  logic [31:0]           AWADDR,
  input  logic [LEN_W-1:0]      AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic [1:0]            AWLOCK,
  input  logic [3:0]            AWCACHE,
  input  logic [2:0]            AWPROT,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [ID_W-1:0]       WID,
  input  logic [buswidth-1:0]   WDATA,
  input  logic [buswidth/8-1:0] WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [ID_W-1:0]       BID,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [buswidth-1:0]   mem_wdata,
  output logic [buswidth/8-1:0] mem_wstrb
);

  localparam int          STRB_W     = buswidth / 8;
  localparam int          OFF_W      = $clog2(STRB_W);
  localparam logic [31:0] ALIGN_MASK = ~(32'(STRB_W) - 32'd1);

  state_e              state_q;
  aw_t                 aw_q;
  logic [LEN_W-1:0]    cnt_q;
  logic                err_q;
  logic                dec_err_q;
  logic                awready_q;
  logic                wready_q;
  logic                bvalid_q;
  logic [ID_W-1:0]     bid_q;
  logic [1:0]          bresp_q;
  logic                mem_we_q;
  logic [31:0]         mem_addr_q;
  logic [buswidth-1:0] mem_wdata_q;
  logic [STRB_W-1:0]   mem_wstrb_q;

  logic [31:0] addr_d;
  logic        aw_dec_err;
  logic        in_range;
  logic        beat_ok;
  logic        last_beat;
  logic        wlast_bad;
  logic        unused_aw_attr;

  assign unused_aw_attr = ^{AWLOCK, AWCACHE, AWPROT};

  axi_burst_addr_gen u_addr_gen (
    .addr_i      (aw_q.addr),
    .size_i      (aw_q.size),
    .len_i       (aw_q.len),
    .burst_i     (aw_q.burst),
    .next_addr_o (addr_d)
  );

  assign aw_dec_err = (AWBURST == BURST_RSVD) ||
                      (AWSIZE > 3'(OFF_W)) ||
                      ((AWBURST == BURST_WRAP) && !wrap_len_ok(AWLEN));

  // 33-bit compare so a window ending at 2^32 does not wrap to zero.
  assign in_range  = ({1'b0, aw_q.addr} >= {1'b0, BASE_ADDR}) &&
                     ({1'b0, aw_q.addr} <  ({1'b0, BASE_ADDR} + 33'(ADDR_SPAN)));
  assign beat_ok   = !dec_err_q && (WID == aw_q.id) && in_range;
  assign last_beat = (cnt_q == aw_q.len);
  assign wlast_bad = (WLAST != last_beat);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= ST_IDLE;
      aw_q        <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      dec_err_q   <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          awready_q <= 1'b1;
          if (AWVALID && awready_q) begin
            aw_q      <= '{id: AWID, addr: AWADDR, len: AWLEN, size: AWSIZE, burst: AWBURST};
            cnt_q     <= '0;
            err_q     <= aw_dec_err;
            dec_err_q <= aw_dec_err;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (WVALID && wready_q) begin
            if (beat_ok) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= aw_q.addr & ALIGN_MASK;
              mem_wdata_q <= WDATA;
              mem_wstrb_q <= WSTRB;
            end
            aw_q.addr <= addr_d;
            cnt_q     <= cnt_q + 4'd1;
            err_q     <= err_q || !beat_ok || wlast_bad;
            // Beat count, not WLAST, closes the burst.
            if (last_beat) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= aw_q.id;
              bresp_q  <= (err_q || !beat_ok || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
              state_q  <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign AWREADY   = awready_q;
  assign WREADY    = wready_q;
  assign BVALID    = bvalid_q;
  assign BID       = bid_q;
  assign BRESP     = bresp_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule
